intlv_seq_ctrl: RTL and testbench

- Sequences one turbo-interleaver frame: latches the PB size at start and derives the frame length L.
- Runs a write phase that stores L input symbols at linear addresses.
- Then runs NPASS read passes of L addresses each; read-side backpressure is honoured.
- Sits between the PB-size configuration and the interleaver buffer RAM; address permutation is applied downstream of rd_addr.

---
 rtl/intlv_seq_ctrl_if.sv | 36 +++
 rtl/intlv_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_intlv_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/intlv_seq_ctrl_if.sv
// Handshake and status bundle between the interleaver frame
// sequencer, its configuration source and the buffer RAM.
interface intlv_seq_ctrl_if #(
  parameter int AW = 12
);
  logic [1:0]    pb_size;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          out_ready;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [3:0]    pass_idx;
  logic [AW-1:0] len_l;
  logic          busy;
  logic          done;

  modport master (
    output pb_size, start, abort,
    output in_valid, out_ready,
    input  in_ready, wr_en, wr_addr,
    input  rd_en, rd_addr, pass_idx,
    input  len_l, busy, done
  );

  modport slave (
    input  pb_size, start, abort,
    input  in_valid, out_ready,
    output in_ready, wr_en, wr_addr,
    output rd_en, rd_addr, pass_idx,
    output len_l, busy, done
  );
endinterface

// File: rtl/intlv_seq_ctrl.sv
// Turbo-interleaver frame sequencer: one linear write phase
// followed by NPASS linear read passes over the frame buffer.
module intlv_seq_ctrl #(
  parameter int AW    = 12,
  parameter int NPASS = 2
) (
  input  logic               clk,
  input  logic               rst,
  intlv_seq_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] rcnt_q, rcnt_d;
  logic [AW-1:0] len_q, len_d;
  logic [3:0]    pass_q, pass_d;
  logic [1:0]    pb_q, pb_d;
  logic [AW-1:0] len_sel;
  logic [AW-1:0] last_idx;

  always_comb begin
    len_sel = AW'(10);
    unique case (pb_q)
      2'd0: len_sel = AW'(64);
      2'd1: len_sel = AW'(544);
      2'd2: len_sel = AW'(2080);
      2'd3: len_sel = AW'(10);
    endcase
  end

  assign last_idx = len_q - AW'(1);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    len_d   = len_q;
    pass_d  = pass_q;
    pb_d    = pb_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pb_d    = bus.pb_size;
          state_d = LOAD;
        end
      end
      LOAD: begin
        len_d   = len_sel;
        wcnt_d  = '0;
        rcnt_d  = '0;
        pass_d  = '0;
        state_d = WRITE;
      end
      WRITE: begin
        if (bus.in_valid) begin
          if (wcnt_q == last_idx) begin
            wcnt_d  = '0;
            state_d = READ;
          end else begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end
      end
      READ: begin
        if (bus.out_ready) begin
          if (rcnt_q == last_idx) begin
            rcnt_d = '0;
            // Next pass starts on the very next cycle.
            if (pass_q == 4'(NPASS - 1)) begin
              state_d = DONE;
            end else begin
              pass_d = pass_q + 4'd1;
            end
          end else begin
            rcnt_d = rcnt_q + AW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a start seen in IDLE.
    if (bus.abort) begin
      state_d = IDLE;
      wcnt_d  = '0;
      rcnt_d  = '0;
      pass_d  = '0;
      pb_d    = pb_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      len_q   <= '0;
      pass_q  <= '0;
      pb_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      len_q   <= len_d;
      pass_q  <= pass_d;
      pb_q    <= pb_d;
    end
  end

  assign bus.in_ready = (state_q == WRITE);
  assign bus.wr_en    = (state_q == WRITE) && bus.in_valid;
  assign bus.wr_addr  = wcnt_q;
  assign bus.rd_en    = (state_q == READ);
  assign bus.rd_addr  = rcnt_q;
  assign bus.pass_idx = pass_q;
  assign bus.len_l    = len_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_intlv_seq_ctrl.sv
// Directed bench for the interleaver frame sequencer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_intlv_seq_ctrl;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;

  intlv_seq_ctrl_if #(.AW(AW)) bus ();

  intlv_seq_ctrl #(.AW(AW), .NPASS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] pb);
    bus.pb_size = pb;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_inrdy"}, 32'(bus.in_ready), 0);
    chk({tag, "_wren"}, 32'(bus.wr_en), 0);
    chk({tag, "_rden"}, 32'(bus.rd_en), 0);
    chk({tag, "_rdaddr"}, 32'(bus.rd_addr), 0);
    chk({tag, "_waddr"}, 32'(bus.wr_addr), 0);
    chk({tag, "_pass"}, 32'(bus.pass_idx), 0);
    chk({tag, "_len"}, 32'(bus.len_l), 0);
  endtask

  initial begin
    int k;
    int r;
    int p;
    int st;
    int exp_w;
    int ndone;

    rst           = 1'b1;
    bus.pb_size   = 2'd0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    outs_zero("rst");
    step();
    step();
    rst = 1'b0;
    step();

    // Test-mode frame, continuous valid/ready.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    start_frame(2'd3);
    chk("t1_load_busy", 32'(bus.busy), 1);
    chk("t1_load_inrdy", 32'(bus.in_ready), 0);
    chk("t1_load_wren", 32'(bus.wr_en), 0);
    step();
    chk("t1_len", 32'(bus.len_l), 10);
    for (int i = 0; i < 10; i++) begin
      chk("t1_wren", 32'(bus.wr_en), 1);
      chk("t1_waddr", 32'(bus.wr_addr), 32'(i));
      chk("t1_rden_w", 32'(bus.rd_en), 0);
      step();
    end
    for (int pp = 0; pp < 2; pp++) begin
      for (int i = 0; i < 10; i++) begin
        chk("t1_rden", 32'(bus.rd_en), 1);
        chk("t1_raddr", 32'(bus.rd_addr), 32'(i));
        chk("t1_pass", 32'(bus.pass_idx), 32'(pp));
        chk("t1_wren_r", 32'(bus.wr_en), 0);
        step();
      end
    end
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_done_busy", 32'(bus.busy), 1);
    chk("t1_done_pass", 32'(bus.pass_idx), 1);
    step();
    chk("t1_done_off", 32'(bus.done), 0);
    chk("t1_idle_busy", 32'(bus.busy), 0);
    chk("t1_len_hold", 32'(bus.len_l), 10);

    // PB16 with in_valid toggling 0/1 every WRITE cycle.
    bus.in_valid  = 1'b0;
    start_frame(2'd0);
    step();
    exp_w = 0;
    for (int c = 0; c < 128; c++) begin
      bus.in_valid = c[0];
      #1;
      chk("t2_wren", 32'(bus.wr_en), 32'(c[0]));
      chk("t2_waddr", 32'(bus.wr_addr), 32'(exp_w));
      if (c[0]) exp_w++;
      step();
    end
    bus.in_valid = 1'b0;
    chk("t2_read", 32'(bus.rd_en), 1);
    chk("t2_len", 32'(bus.len_l), 64);
    k = 0;
    while (!bus.done && k < 400) begin
      step();
      k++;
    end
    chk("t2_done", 32'(bus.done), 1);
    chk("t2_read_cycles", 32'(k), 128);
    step();
    chk("t2_idle", 32'(bus.busy), 0);

    // PB520 with a 5-cycle read stall at rcnt=100.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    start_frame(2'd2);
    step();
    chk("t3_len", 32'(bus.len_l), 2080);
    for (int i = 0; i < 2080; i++) begin
      chk("t3_waddr", 32'(bus.wr_addr), 32'(i));
      step();
    end
    bus.in_valid = 1'b0;
    r  = 0;
    p  = 0;
    st = 0;
    k  = 0;
    while (p < 2 && k < 5000) begin
      bus.out_ready = !(p == 0 && r == 100 && st < 5);
      chk("t3_raddr", 32'(bus.rd_addr), 32'(r));
      chk("t3_rden", 32'(bus.rd_en), 1);
      chk("t3_pass", 32'(bus.pass_idx), 32'(p));
      if (!bus.out_ready) st++;
      else if (r == 2079) begin
        r = 0;
        p++;
      end else r++;
      step();
      k++;
    end
    bus.out_ready = 1'b1;
    chk("t3_read_cycles", 32'(k), 4165);
    chk("t3_done", 32'(bus.done), 1);
    step();
    chk("t3_idle", 32'(bus.busy), 0);

    // Abort mid-WRITE of a PB136 frame.
    bus.in_valid = 1'b1;
    start_frame(2'd1);
    step();
    for (int i = 0; i < 300; i++) step();
    chk("t4_waddr300", 32'(bus.wr_addr), 300);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t4_busy", 32'(bus.busy), 0);
    chk("t4_done", 32'(bus.done), 0);
    chk("t4_len", 32'(bus.len_l), 544);
    chk("t4_wren", 32'(bus.wr_en), 0);
    chk("t4_waddr", 32'(bus.wr_addr), 0);
    step();
    chk("t4_still_idle", 32'(bus.busy), 0);
    start_frame(2'd0);
    step();
    chk("t4_len_new", 32'(bus.len_l), 64);
    chk("t4_waddr_new", 32'(bus.wr_addr), 0);
    chk("t4_wren_new", 32'(bus.wr_en), 1);
    bus.abort = 1'b1;
    step();
    chk("t4_abort2", 32'(bus.busy), 0);
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("t4_abort_start", 32'(bus.busy), 0);

    // start during READ and together with DONE are both ignored.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    start_frame(2'd3);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done) ndone++;
      bus.start = (c == 15) || bus.done;
      step();
    end
    bus.start = 1'b0;
    chk("t5_ndone", 32'(ndone), 1);
    chk("t5_idle", 32'(bus.busy), 0);
    start_frame(2'd3);
    chk("t5_restart", 32'(bus.busy), 1);
    step();
    chk("t5_inrdy", 32'(bus.in_ready), 1);
    chk("t5_waddr", 32'(bus.wr_addr), 0);

    // Asynchronous reset while in READ.
    for (int i = 0; i < 13; i++) step();
    chk("t6_raddr", 32'(bus.rd_addr), 3);
    chk("t6_rden", 32'(bus.rd_en), 1);
    #1;
    rst = 1'b1;
    #1;
    outs_zero("t6_rst");
    step();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    chk("t6_idle", 32'(bus.busy), 0);
    start_frame(2'd3);
    chk("t6_load", 32'(bus.busy), 1);
    step();
    chk("t6_len", 32'(bus.len_l), 10);
    chk("t6_inrdy", 32'(bus.in_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
